// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and types.
// Phase units are 1e-4 degree, so 90_0000 is 90 degrees.
// The quadrant type and helper are shared with the core's pre-map stage.
package cordic_pkg;

   localparam int PHASE_W   = 22;
   localparam int ANGLE_90  = 90_0000;
   localparam int ANGLE_180 = 180_0000;
   localparam int ANGLE_360 = 360_0000;

   typedef enum logic [1:0] {
      QUAD_I   = 2'd0,
      QUAD_II  = 2'd1,
      QUAD_III = 2'd2,
      QUAD_IV  = 2'd3
   } quad_e;

   // Quadrant of a phase that is already normalized to +/-180 degrees.
   function automatic quad_e phase_quad(input int p);
      if (p >= ANGLE_90)       return QUAD_II;
      else if (p >= 0)         return QUAD_I;
      else if (p >= -ANGLE_90) return QUAD_IV;
      else                     return QUAD_III;
   endfunction

endpackage

// File: rtl/cordic_sched_if.sv
// Bus between the requesters, the scheduler and the shared CORDIC core.
// slave  : scheduler view (takes requests and core results, drives the rest)
// master : environment view (requesters, core model, result consumer)
// req_phase packs requester i at bits [i*PHASE_W +: PHASE_W].
interface cordic_sched_if #(
   parameter int NUM_REQ = 2,
   parameter int PHASE_W = 22,
   parameter int DATA_W  = 16
);
   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ*PHASE_W-1:0] req_phase;
   logic [NUM_REQ-1:0]         req_ready;
   logic                       core_valid;
   logic [PHASE_W-1:0]         core_phase;
   logic [DATA_W-1:0]          core_cos;
   logic [DATA_W-1:0]          core_sin;
   logic                       rsp_valid;
   logic [IDW-1:0]             rsp_id;
   logic [DATA_W-1:0]          rsp_cos;
   logic [DATA_W-1:0]          rsp_sin;
   logic                       err_range;

   modport slave (
      input  req_valid, req_phase, core_cos, core_sin,
      output req_ready, core_valid, core_phase,
             rsp_valid, rsp_id, rsp_cos, rsp_sin, err_range
   );

   modport master (
      output req_valid, req_phase, core_cos, core_sin,
      input  req_ready, core_valid, core_phase,
             rsp_valid, rsp_id, rsp_cos, rsp_sin, err_range
   );

endinterface

// File: rtl/cordic_sched_rr_arbiter.sv
// Round-robin arbiter, N requesters.
// Ports: clk, aresetn (async active-low); req (request vector);
//        advance (move the pointer past the current grant);
//        grant (one-hot, combinational); grant_idx (index of grant).
// The pointer names the requester with highest priority this cycle.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          aresetn,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] ptr_q, ptr_d;
   int            idx;

   // Scan from the pointer upward, wrapping; first hit wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      idx       = 0;
      for (int off = 0; off < N; off++) begin
         idx = int'(ptr_q) + off;
         if (idx >= N) idx = idx - N;
         if (grant == '0 && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = IW'(idx);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance && grant != '0)
         ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) ptr_q <= '0;
      else          ptr_q <= ptr_d;
   end

endmodule

// File: rtl/cordic_sched.sv
// CORDIC scheduler: shares one fixed-latency cos/sin core between NUM_REQ
// requesters. One round-robin grant per cycle; the granted phase is folded
// into +/-180 degrees and issued one cycle later; a {valid,id} tag line of
// depth CORDIC_LAT tracks each issue so the result returns with its owner.
// Ports: clk, aresetn (async active-low), bus (cordic_sched_if.slave).
// Optional macro CORDIC_SCHED_STATS_EN adds:
//    grant_cnt : per-requester saturating 16-bit grant counters
//    busy_max  : peak in-flight count, saturating at 255
module cordic_sched
   import cordic_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int PHASE_W    = cordic_pkg::PHASE_W,
   parameter int DATA_W     = 16,
   parameter int CORDIC_LAT = 18
) (
   input  logic                    clk,
   input  logic                    aresetn,
   cordic_sched_if.slave           bus
`ifdef CORDIC_SCHED_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]   grant_cnt,
   output logic [7:0]              busy_max
`endif
);

   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]         grant;
   logic [IDW-1:0]             gidx;
   logic                       gv;
   logic signed [PHASE_W-1:0]  gphase, norm;
   int                         p_ext;
   logic                       oor;

   logic                       core_valid_q;
   logic [PHASE_W-1:0]         core_phase_q;
   logic [IDW-1:0]             core_id_q;
   logic [CORDIC_LAT-1:0]      vld_pipe_q;
   logic [CORDIC_LAT-1:0][IDW-1:0] id_pipe_q;
   logic                       rsp_valid_q;
   logic [IDW-1:0]             rsp_id_q;
   logic [DATA_W-1:0]          rsp_cos_q, rsp_sin_q;
   logic                       err_q;

   rr_arbiter #(.N(NUM_REQ), .IW(IDW)) u_arb (
      .clk       (clk),
      .aresetn   (aresetn),
      .req       (bus.req_valid),
      .advance   (gv),
      .grant     (grant),
      .grant_idx (gidx)
   );

   assign gv = |grant;

   // Single-step fold; out-of-range inputs are still folded once and flagged.
   always_comb begin
      gphase = bus.req_phase[int'(gidx)*PHASE_W +: PHASE_W];
      p_ext  = int'(gphase);
      norm   = gphase;
      if (p_ext > ANGLE_180)       norm = PHASE_W'(p_ext - ANGLE_360);
      else if (p_ext < -ANGLE_180) norm = PHASE_W'(p_ext + ANGLE_360);
      oor = (p_ext > ANGLE_360) || (p_ext < -ANGLE_360);
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         core_valid_q <= 1'b0;
         core_phase_q <= '0;
         core_id_q    <= '0;
         vld_pipe_q   <= '0;
         id_pipe_q    <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_cos_q    <= '0;
         rsp_sin_q    <= '0;
         err_q        <= 1'b0;
      end else begin
         core_valid_q <= gv;
         if (gv) begin
            core_phase_q <= norm;
            core_id_q    <= gidx;
         end
         if (gv && oor) err_q <= 1'b1;
         // Tag enters in the core_valid cycle so its tail meets core data.
         vld_pipe_q[0] <= core_valid_q;
         id_pipe_q[0]  <= core_id_q;
         for (int i = 1; i < CORDIC_LAT; i++) begin
            vld_pipe_q[i] <= vld_pipe_q[i-1];
            id_pipe_q[i]  <= id_pipe_q[i-1];
         end
         rsp_valid_q <= vld_pipe_q[CORDIC_LAT-1];
         if (vld_pipe_q[CORDIC_LAT-1]) begin
            rsp_id_q  <= id_pipe_q[CORDIC_LAT-1];
            rsp_cos_q <= bus.core_cos;
            rsp_sin_q <= bus.core_sin;
         end
      end
   end

   assign bus.req_ready  = grant;
   assign bus.core_valid = core_valid_q;
   assign bus.core_phase = core_phase_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_cos    = rsp_cos_q;
   assign bus.rsp_sin    = rsp_sin_q;
   assign bus.err_range  = err_q;

`ifdef CORDIC_SCHED_STATS_EN
   logic [NUM_REQ-1:0][15:0] gcnt_q;
   logic [7:0]               bmax_q;
   int                       inflight;

   // In flight = issued to the core and not yet returned by it.
   always_comb begin
      inflight = int'(core_valid_q);
      for (int i = 0; i < CORDIC_LAT; i++) inflight = inflight + int'(vld_pipe_q[i]);
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         gcnt_q <= '0;
         bmax_q <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++)
            if (grant[i] && gcnt_q[i] != 16'hFFFF) gcnt_q[i] <= gcnt_q[i] + 16'd1;
         if (inflight > int'(bmax_q)) bmax_q <= (inflight > 255) ? 8'hFF : 8'(inflight);
      end
   end

   assign grant_cnt = gcnt_q;
   assign busy_max  = bmax_q;
`endif

endmodule

// File: tb/tb_cordic_sched.sv
module tb_cordic_sched;
   localparam int NR  = 2;
   localparam int PW  = 24;   // wide enough to present phases beyond +/-360 deg
   localparam int DW  = 16;
   localparam int LAT = 18;

   logic clk = 1'b0;
   logic aresetn = 1'b0;
   always #5 clk = ~clk;

   cordic_sched_if #(.NUM_REQ(NR), .PHASE_W(PW), .DATA_W(DW)) bus ();

`ifdef CORDIC_SCHED_STATS_EN
   logic [NR*16-1:0] grant_cnt;
   logic [7:0]       busy_max;
`endif

   cordic_sched #(.NUM_REQ(NR), .PHASE_W(PW), .DATA_W(DW), .CORDIC_LAT(LAT)) dut (
      .clk     (clk),
      .aresetn (aresetn),
      .bus     (bus)
`ifdef CORDIC_SCHED_STATS_EN
      ,
      .grant_cnt (grant_cnt),
      .busy_max  (busy_max)
`endif
   );

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- spec-level model helpers ----------------
   function automatic int fold(input int p);
      if (p > 1800000)       return p - 3600000;
      else if (p < -1800000) return p + 3600000;
      return p;
   endfunction

   function automatic bit out_of_range(input int p);
      return (p > 3600000) || (p < -3600000);
   endfunction

   // Fake core: results are a recognisable function of the issued phase.
   function automatic logic [DW-1:0] fcos(input logic [PW-1:0] p);
      return p[15:0] ^ 16'h5A5A;
   endfunction
   function automatic logic [DW-1:0] fsin(input logic [PW-1:0] p);
      return p[23:8];
   endfunction

   // ---------------- fake CORDIC core ----------------
   logic          hv[64];
   logic [PW-1:0] hp[64];

   initial begin
      bus.core_cos = '0;
      bus.core_sin = '0;
      forever begin
         @(posedge clk);
         #1;
         if (cyc >= LAT && hv[(cyc - LAT) % 64] === 1'b1) begin
            bus.core_cos = fcos(hp[(cyc - LAT) % 64]);
            bus.core_sin = fsin(hp[(cyc - LAT) % 64]);
         end else begin
            bus.core_cos = DW'($urandom);
            bus.core_sin = DW'($urandom);
         end
      end
   end

   // ---------------- model + per-cycle compare ----------------
   typedef struct {int due; int id; int ph;} ent_t;
   ent_t q[$];
   int   mptr = 0;
   bit   exp_cv = 0;
   int   exp_cp = 0;
   bit   exp_err = 0;
   logic [DW-1:0] last_cos = '0, last_sin = '0;

   initial begin
      forever begin
         @(negedge clk);
         hv[cyc % 64] = bus.core_valid;
         hp[cyc % 64] = bus.core_phase;
         if (!aresetn) begin
            chk("rst_core_valid", bus.core_valid, 0);
            chk("rst_rsp_valid",  bus.rsp_valid, 0);
            chk("rst_err_range",  bus.err_range, 0);
            mptr = 0; exp_cv = 0; exp_cp = 0; exp_err = 0;
            last_cos = '0; last_sin = '0;
            q.delete();
         end else begin
            int g;
            int exp_ready;
            g = -1;
            for (int off = 0; off < NR; off++)
               if (g < 0 && bus.req_valid[(mptr + off) % NR]) g = (mptr + off) % NR;
            exp_ready = (g < 0) ? 0 : (1 << g);
            chk("req_ready",  bus.req_ready, exp_ready);
            chk("core_valid", bus.core_valid, exp_cv);
            chk("core_phase", $signed(bus.core_phase), exp_cp);
            chk("err_range",  bus.err_range, exp_err);
            if (q.size() > 0 && q[0].due == cyc) begin
               chk("rsp_valid", bus.rsp_valid, 1);
               chk("rsp_id",    bus.rsp_id, q[0].id);
               last_cos = fcos(PW'(q[0].ph));
               last_sin = fsin(PW'(q[0].ph));
               chk("rsp_cos", bus.rsp_cos, last_cos);
               chk("rsp_sin", bus.rsp_sin, last_sin);
               void'(q.pop_front());
            end else begin
               chk("rsp_idle",     bus.rsp_valid, 0);
               chk("rsp_cos_hold", bus.rsp_cos, last_cos);
               chk("rsp_sin_hold", bus.rsp_sin, last_sin);
            end
            exp_cv = (g >= 0);
            if (g >= 0) begin
               int p;
               p = int'($signed(bus.req_phase[g*PW +: PW]));
               exp_cp = fold(p);
               if (out_of_range(p)) exp_err = 1;
               q.push_back('{cyc + LAT + 2, g, exp_cp});
               mptr = (g + 1) % NR;
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int id, input int ph);
      bus.req_valid[id] = 1'b1;
      bus.req_phase[id*PW +: PW] = PW'(ph);
   endtask

   int tbl[6] = '{-1800000, 1800001, -1800001, 3600000, -3600000, 1799999};
   int g0;

   initial begin
      bus.req_valid = '0;
      bus.req_phase = '0;
      #2;
      chk("reset_ready",      bus.req_ready, 0);
      chk("reset_core_valid", bus.core_valid, 0);
      chk("reset_core_phase", bus.core_phase, 0);
      chk("reset_rsp_valid",  bus.rsp_valid, 0);
      chk("reset_err",        bus.err_range, 0);
      repeat (2) @(posedge clk);
      #1 aresetn = 1'b1;
      next_cyc();

      // Both requesters continuously: grants must alternate 0,1,0,1,...
      set_req(0, 1000);
      set_req(1, -2000000);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("alt_grant", bus.req_ready, (k % 2 == 0) ? 1 : 2);
         next_cyc();
      end
      bus.req_valid = '0;

      // Single request, requester 0, 45 deg.
      set_req(0, 450000);
      @(negedge clk);
      g0 = cyc;
      chk("single_ready", bus.req_ready, 1);
      next_cyc();
      bus.req_valid = '0;
      @(negedge clk);
      chk("single_core_valid", bus.core_valid, 1);
      chk("single_core_phase", $signed(bus.core_phase), 450000);
      repeat (19) @(negedge clk);
      chk("single_lat_cyc",  cyc - g0, LAT + 2);
      chk("single_rsp_valid", bus.rsp_valid, 1);
      chk("single_rsp_id",    bus.rsp_id, 0);
      chk("single_rsp_cos",   bus.rsp_cos, 16'h878A);
      chk("single_rsp_sin",   bus.rsp_sin, 16'h06DD);
      next_cyc();

      // Fold to +/-180 deg.
      set_req(0, 2000000);
      next_cyc();
      set_req(0, -2500000);
      @(negedge clk);
      chk("fold_200", $signed(bus.core_phase), -1600000);
      next_cyc();
      set_req(0, 1800000);
      @(negedge clk);
      chk("fold_m250", $signed(bus.core_phase), 1100000);
      next_cyc();
      bus.req_valid = '0;
      @(negedge clk);
      chk("fold_180", $signed(bus.core_phase), 1800000);
      chk("fold_err_clear", bus.err_range, 0);
      next_cyc();

      // Boundary table from requester 1 (model checks each value).
      foreach (tbl[i]) begin
         set_req(1, tbl[i]);
         next_cyc();
      end
      bus.req_valid = '0;
      @(negedge clk);
      chk("bound_err_clear", bus.err_range, 0);
      next_cyc();

      // Out of range: folded once, err_range sticky.
      set_req(0, 4000000);
      next_cyc();
      bus.req_valid = '0;
      @(negedge clk);
      chk("oor_phase", $signed(bus.core_phase), 400000);
      chk("oor_err",   bus.err_range, 1);
      repeat (25) next_cyc();
      chk("oor_err_sticky", bus.err_range, 1);

      // Reset with 5 requests in flight.
      for (int k = 0; k < 5; k++) begin
         set_req(0, 100000 * (k + 1));
         next_cyc();
      end
      bus.req_valid = '0;
      repeat (3) next_cyc();
      aresetn = 1'b0;
      #1;
      chk("midrst_core_valid", bus.core_valid, 0);
      chk("midrst_core_phase", bus.core_phase, 0);
      chk("midrst_rsp_valid",  bus.rsp_valid, 0);
      chk("midrst_err",        bus.err_range, 0);
      chk("midrst_rsp_cos",    bus.rsp_cos, 0);
      @(negedge clk);
      next_cyc();
      aresetn = 1'b1;
      repeat (25) next_cyc();
      set_req(0, 0);
      set_req(1, 0);
      @(negedge clk);
      chk("ptr_after_reset", bus.req_ready, 1);
      next_cyc();
      bus.req_valid = '0;

`ifdef CORDIC_SCHED_STATS_EN
      set_req(1, 0);
      repeat (70000) next_cyc();
      bus.req_valid = '0;
      chk("grant_cnt1_sat", grant_cnt[31:16], 16'hFFFF);
`endif

      repeat (25) next_cyc();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
